clock_in_monitor: RTL

CLOCK_IN_MONITOR -- requirements
Module: clock_in_monitor

---
 rtl/clock_in_monitor_pkg.sv | 18 +
 rtl/sync_bit.sv | 24 ++
 rtl/clock_in_monitor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_in_monitor_pkg.sv
// Shared definitions for the forwarded-clock monitor: FSM encoding and
// default parameter values.
package clock_in_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int PERIOD_W_DEF    = 16;
   localparam int TIMEOUT_DEF     = 64;
   localparam int LOCK_COUNT_DEF  = 8;
   localparam int TOL_DEF         = 1;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to zero.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stage_r;

   // shift chain, oldest sample at the top
   always_ff @(posedge clk_in) begin
      if (rst) begin
         stage_r <= {STAGES{1'b0}};
      end else begin
         stage_r <= {stage_r[STAGES-2:0], d};
      end
   end

   assign q = stage_r[STAGES-1];

endmodule

// File: rtl/clock_in_monitor.sv
// Measures the period of a forwarded clock in clk_in cycles and reports
// lock when consecutive periods agree within a tolerance.
module clock_in_monitor
   import clock_in_monitor_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int PERIOD_W    = PERIOD_W_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
   parameter int TOL         = TOL_DEF
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                clk_ext,
   output logic                edge_pulse,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                locked,
   output logic                lost_pulse
);

   localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
   localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

   localparam logic [PERIOD_W-1:0] CNT_MAX      = {PERIOD_W{1'b1}};
   localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = PERIOD_W'(TIMEOUT - 1);
   localparam logic [MATCH_W-1:0]  LOCK_TARGET  = MATCH_W'(LOCK_COUNT);
   localparam logic [PERIOD_W:0]   TOL_LIM      = (PERIOD_W + 1)'(TOL);
   localparam logic [SETTLE_W-1:0] SETTLE_DONE  = SETTLE_W'(SYNC_STAGES + 1);

   logic                sync_q_s;
   logic                hist_r;
   logic [SETTLE_W-1:0] settle_r;
   logic                edge_s;
   logic [PERIOD_W-1:0] cnt_r;
   logic                sat_s;
   logic [PERIOD_W-1:0] meas_s;
   logic                in_tol_s;
   logic                timeout_s;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [PERIOD_W-1:0] ref_r;
   logic [PERIOD_W-1:0] ref_nxt_s;
   logic                ref_valid_r;
   logic                ref_valid_nxt_s;
   logic [MATCH_W-1:0]  match_cnt_r;
   logic [MATCH_W-1:0]  match_nxt_s;

   function automatic logic within_tol(input logic [PERIOD_W-1:0] a,
                                       input logic [PERIOD_W-1:0] b);
      logic signed [PERIOD_W:0] diff_s;
      logic        [PERIOD_W:0] mag_s;
      diff_s = $signed({1'b0, a}) - $signed({1'b0, b});
      mag_s  = diff_s[PERIOD_W] ? $unsigned(-diff_s) : $unsigned(diff_s);
      return (mag_s <= TOL_LIM);
   endfunction

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .d      (clk_ext),
      .q      (sync_q_s)
   );

   // history flop behind the synchronizer
   always_ff @(posedge clk_in) begin
      if (rst) begin
         hist_r <= 1'b0;
      end else begin
         hist_r <= sync_q_s;
      end
   end

   // Edges are suppressed until the synchronizer and history flop hold real
   // samples, so a clk_ext already high out of reset is not seen as a rise.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         settle_r <= {SETTLE_W{1'b0}};
      end else if (settle_r != SETTLE_DONE) begin
         settle_r <= settle_r + 1'b1;
      end else begin
         settle_r <= settle_r;
      end
   end

   assign edge_s    = sync_q_s & ~hist_r & (settle_r == SETTLE_DONE);
   assign sat_s     = (cnt_r == CNT_MAX);
   assign meas_s    = sat_s ? CNT_MAX : (cnt_r + 1'b1);
   assign in_tol_s  = ~sat_s & within_tol(meas_s, ref_r);
   assign timeout_s = (cnt_r == TIMEOUT_LAST) & ~edge_s;

   // period counter: cleared on edges, saturating otherwise
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_r <= {PERIOD_W{1'b0}};
      end else if (edge_s) begin
         cnt_r <= {PERIOD_W{1'b0}};
      end else if (sat_s) begin
         cnt_r <= cnt_r;
      end else begin
         cnt_r <= cnt_r + 1'b1;
      end
   end

   // acquisition FSM next state and reference tracking
   always_comb begin
      state_nxt_s     = state_r;
      ref_nxt_s       = ref_r;
      ref_valid_nxt_s = ref_valid_r;
      match_nxt_s     = match_cnt_r;
      case (state_r)
         IDLE: begin
            if (edge_s) begin
               state_nxt_s     = ACQUIRE;
               ref_valid_nxt_s = 1'b0;
               match_nxt_s     = {MATCH_W{1'b0}};
            end else begin
               state_nxt_s     = IDLE;
            end
         end
         ACQUIRE: begin
            if (edge_s) begin
               if (!ref_valid_r) begin
                  ref_nxt_s       = meas_s;
                  ref_valid_nxt_s = 1'b1;
                  match_nxt_s     = {MATCH_W{1'b0}};
               end else if (in_tol_s) begin
                  match_nxt_s = match_cnt_r + 1'b1;
                  if ((match_cnt_r + 1'b1) == LOCK_TARGET) begin
                     state_nxt_s = LOCKED;
                  end else begin
                     state_nxt_s = ACQUIRE;
                  end
               end else begin
                  ref_nxt_s   = meas_s;
                  match_nxt_s = {MATCH_W{1'b0}};
               end
            end else if (timeout_s) begin
               state_nxt_s     = IDLE;
               ref_valid_nxt_s = 1'b0;
               match_nxt_s     = {MATCH_W{1'b0}};
            end else begin
               state_nxt_s     = ACQUIRE;
            end
         end
         LOCKED: begin
            if ((edge_s && !in_tol_s) || timeout_s) begin
               state_nxt_s = LOST;
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         LOST: begin
            // any edge here is deliberately not used for acquisition
            state_nxt_s     = IDLE;
            ref_valid_nxt_s = 1'b0;
            match_nxt_s     = {MATCH_W{1'b0}};
         end
         default: begin
            state_nxt_s     = IDLE;
            ref_valid_nxt_s = 1'b0;
            match_nxt_s     = {MATCH_W{1'b0}};
         end
      endcase
   end

   // FSM and reference registers
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_r     <= IDLE;
         ref_r       <= {PERIOD_W{1'b0}};
         ref_valid_r <= 1'b0;
         match_cnt_r <= {MATCH_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         ref_r       <= ref_nxt_s;
         ref_valid_r <= ref_valid_nxt_s;
         match_cnt_r <= match_nxt_s;
      end
   end

   // registered outputs, aligned with the state register update
   always_ff @(posedge clk_in) begin
      if (rst) begin
         edge_pulse   <= 1'b0;
         period       <= {PERIOD_W{1'b0}};
         period_valid <= 1'b0;
         locked       <= 1'b0;
         lost_pulse   <= 1'b0;
      end else begin
         edge_pulse   <= edge_s;
         period_valid <= edge_s & (state_r != IDLE);
         if (edge_s && (state_r != IDLE)) begin
            period <= meas_s;
         end else begin
            period <= period;
         end
         locked       <= (state_nxt_s == LOCKED);
         lost_pulse   <= (state_nxt_s == LOST);
      end
   end

endmodule
